median_filter_stream: RTL and testbench
=======================================

MEDIAN_FILTER_STREAM -- requirements
Module: median_filter_stream

Interface
REQ-001 Parameter DATA_W, default 8, sample width in bits (legal: 2..32).
REQ-002 Parameter WIN, default 3, window length (legal: 3, 5, 7; odd only; elaboration error otherwise).
REQ-003 Parameter SIGNED, default 1, 1 = two's-complement compare, 0 = unsigned compare.
REQ-004 clk  input  1  single clock, rising edge.
REQ-005 rst_n  input  1  asynchronous, active-low reset.
REQ-006 flush  input  1  synchronous clear of window and output stage.
REQ-007 in_valid  input  1  input sample offered.
REQ-008 in_data  input  DATA_W  input sample.
REQ-009 in_ready  output  1  block accepts a sample this cycle.
REQ-010 out_valid  output  1  out_data holds a median.
REQ-011 out_data  output  DATA_W  median of the last WIN accepted samples.
REQ-012 out_ready  input  1  downstream consumes out_data.

Function
REQ-013 The block SHALL accept a sample on a rising clk edge where in_valid && in_ready && !flush.
REQ-014 in_ready SHALL equal !out_valid || out_ready (combinational, one-deep output skid).
REQ-015 Window: WIN-entry shift register; on accept, entry 0 takes in_data and entry k takes entry k-1.
REQ-016 States: FILL (fewer than WIN samples held) and RUN (window full).
REQ-017 FILL: fill counter (width clog2(WIN+1)) increments per accept; on the accept that makes WIN samples -> RUN.
REQ-018 RUN: SHALL remain in RUN until reset or flush; every accept produces one output.
REQ-019 Accepts in FILL that do not complete the window SHALL produce no output.
REQ-020 Latency: median of the window including the sample accepted at edge N SHALL appear with out_valid=1 after edge N (registered output, 1 cycle).
REQ-021 Median: element of rank (WIN-1)/2 in ascending order; ties broken by window index (lower index ranks lower), so exactly one element is selected.
REQ-022 Compare SHALL be signed when SIGNED=1, unsigned when SIGNED=0; out_data is a copy of a window entry, never an arithmetic result.
REQ-023 out_valid && !out_ready SHALL hold out_data and out_valid stable; no sample is accepted.
REQ-024 out_valid SHALL clear after an edge with out_ready=1 and no new accept; accept and consume on the same edge SHALL keep out_valid=1 with new data.
REQ-025 flush=1 SHALL on that edge clear fill counter, enter FILL, clear out_valid; a simultaneous in_valid sample is dropped; window contents are don't-care.
REQ-026 flush has priority over accept and over consume.

Reset
REQ-027 rst_n low SHALL immediately force: state FILL, fill counter 0, out_valid 0, out_data 0, window entries 0.
REQ-028 in_ready SHALL read 1 during and after reset (follows REQ-014).
REQ-029 Reset asserted mid-operation SHALL discard all held samples; the first output after release requires WIN fresh accepts.

Structure
REQ-030 Shared package median_pkg SHALL hold the FILL/RUN state type and the clog2-based counter-width function.
REQ-031 Rank selection SHALL be one sub-module, median_rank (parameters DATA_W, WIN, SIGNED; input packed window; output selected sample), purely combinational.
REQ-032 Top level holds window register, fill FSM and output register only; RTL budget 120-400 lines total.

Verification
REQ-033 DATA_W=8, WIN=3, SIGNED=1, out_ready=1: accept 0x0A, 0xFB, 0x03 -> single output 0x03 one cycle after third accept; no output after first two.
REQ-034 DATA_W=8, WIN=3: accept 0xF0, 0x10, 0x80 -> output 0xF0 with SIGNED=1, 0x80 with SIGNED=0; then 0x07, 0x07 -> outputs 0x10 (window 0x80,0x07,0x10... verify per REQ-021) and 0x07; tie window 0x07,0x07,0x02 -> 0x07.
REQ-035 WIN=5, SIGNED=0: accept 1, 9, 4, 9, 0 -> output 4; then 2 -> window 9,4,9,0,2 -> output 4.
REQ-036 Backpressure: out_ready=0 with out_valid=1 for 5 cycles, in_valid=1 -> in_ready=0, out_data constant, no sample lost; out_ready=1 -> next median follows in order.
REQ-037 Flush after 2 accepts (with in_valid=1 on flush edge), then accept 1, 2, 3 -> no output until third, output 0x02; flushed sample absent.
REQ-038 rst_n pulsed low asynchronously (mid-cycle) while in RUN with out_valid=1 -> out_valid drops without clock edge; next output only after WIN new accepts.

Source files
------------

// File: rtl/median_pkg.sv
// Shared types for the streaming median filter: fill/run state and counter sizing.
// Pure declarations; no logic, so no latency or backpressure of its own.
package median_pkg;

  typedef enum logic {
    ST_FILL = 1'b0,
    ST_RUN  = 1'b1
  } fill_state_t;

  // Width able to hold the values 0..n inclusive.
  function automatic int cnt_width(input int n);
    return $clog2(n + 1);
  endfunction

endpackage

// File: rtl/median_rank.sv
// Picks the rank-(WIN-1)/2 sample of a packed window; equal values are ordered by window index.
// Purely combinational: zero latency, no flow control.
module median_rank #(
  parameter int DATA_W = 8,
  parameter int WIN    = 3,
  parameter int SIGNED = 1
) (
  input  logic [WIN*DATA_W-1:0] win_i,
  output logic [DATA_W-1:0]     med_o
);

  localparam int MID = (WIN - 1) / 2;
  localparam int RW  = $clog2(WIN);

  logic [DATA_W-1:0] smp [WIN];
  logic [WIN-1:0]    is_mid;

  function automatic logic smp_lt(input logic [DATA_W-1:0] a, input logic [DATA_W-1:0] b);
    if (SIGNED != 0) return $signed(a) < $signed(b);
    else             return a < b;
  endfunction

  for (genvar i = 0; i < WIN; i++) begin : g_rank
    logic [RW-1:0] below;

    assign smp[i] = win_i[i*DATA_W +: DATA_W];

    // Index tie-break makes every rank unique, so exactly one is_mid bit is set.
    always_comb begin
      below = '0;
      for (int j = 0; j < WIN; j++) begin
        if (j != i) begin
          if (smp_lt(smp[j], smp[i]) || ((smp[j] == smp[i]) && (j < i))) begin
            below = below + RW'(1);
          end
        end
      end
    end

    assign is_mid[i] = (below == RW'(MID));
  end

  always_comb begin
    med_o = '0;
    for (int i = 0; i < WIN; i++) begin
      if (is_mid[i]) med_o = smp[i];
    end
  end

endmodule

// File: rtl/median_filter_stream.sv
// Streaming median over the last WIN accepted samples with a registered output stage.
// Latency 1 cycle from the completing accept; in_ready = !out_valid || out_ready.
module median_filter_stream
  import median_pkg::*;
#(
  parameter int DATA_W = 8,
  parameter int WIN    = 3,
  parameter int SIGNED = 1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              flush,
  input  logic              in_valid,
  input  logic [DATA_W-1:0] in_data,
  output logic              in_ready,
  output logic              out_valid,
  output logic [DATA_W-1:0] out_data,
  input  logic              out_ready
);

  localparam int CNT_W = cnt_width(WIN);
  localparam logic [CNT_W-1:0] FILL_LAST = CNT_W'(WIN - 1);
  localparam logic [CNT_W-1:0] FILL_FULL = CNT_W'(WIN);

  if (!((WIN == 3) || (WIN == 5) || (WIN == 7))) begin : g_bad_win
    $error("median_filter_stream: WIN must be 3, 5 or 7");
  end
  if ((DATA_W < 2) || (DATA_W > 32)) begin : g_bad_width
    $error("median_filter_stream: DATA_W must be within 2..32");
  end

  fill_state_t       state_q, state_d;
  logic [CNT_W-1:0]  fill_q, fill_d;
  logic              out_valid_q, out_valid_d;
  logic [DATA_W-1:0] out_data_q, out_data_d;
  logic [DATA_W-1:0] win_q [WIN];
  logic [DATA_W-1:0] win_d [WIN];
  logic [DATA_W-1:0] shift_w [WIN];
  logic [WIN*DATA_W-1:0] shift_flat;
  logic [DATA_W-1:0] med;
  logic              accept;

  assign in_ready  = !out_valid_q || out_ready;
  assign accept    = in_valid && in_ready && !flush;
  assign out_valid = out_valid_q;
  assign out_data  = out_data_q;

  // The median is taken over the window as it will look after this accept.
  always_comb begin
    shift_w[0] = in_data;
    for (int k = 1; k < WIN; k++) begin
      shift_w[k] = win_q[k-1];
    end
    shift_flat = '0;
    for (int k = 0; k < WIN; k++) begin
      shift_flat[k*DATA_W +: DATA_W] = shift_w[k];
    end
  end

  median_rank #(
    .DATA_W (DATA_W),
    .WIN    (WIN),
    .SIGNED (SIGNED)
  ) u_rank (
    .win_i (shift_flat),
    .med_o (med)
  );

  always_comb begin
    state_d     = state_q;
    fill_d      = fill_q;
    out_valid_d = out_valid_q;
    out_data_d  = out_data_q;
    win_d       = win_q;
    if (flush) begin
      state_d     = ST_FILL;
      fill_d      = '0;
      out_valid_d = 1'b0;
    end else begin
      if (out_ready) out_valid_d = 1'b0;
      if (accept) begin
        win_d = shift_w;
        case (state_q)
          ST_FILL: begin
            if (fill_q == FILL_LAST) begin
              state_d     = ST_RUN;
              fill_d      = FILL_FULL;
              out_valid_d = 1'b1;
              out_data_d  = med;
            end else begin
              fill_d = fill_q + CNT_W'(1);
            end
          end
          ST_RUN: begin
            out_valid_d = 1'b1;
            out_data_d  = med;
          end
          default: begin
            state_d = ST_FILL;
            fill_d  = '0;
          end
        endcase
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= ST_FILL;
      fill_q      <= '0;
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
      for (int k = 0; k < WIN; k++) begin
        win_q[k] <= '0;
      end
    end else begin
      state_q     <= state_d;
      fill_q      <= fill_d;
      out_valid_q <= out_valid_d;
      out_data_q  <= out_data_d;
      for (int k = 0; k < WIN; k++) begin
        win_q[k] <= win_d[k];
      end
    end
  end

endmodule

// File: tb/tb_median_filter_stream.sv
// Three filter variants driven by one shared stream, each checked against a sort-based model.
module tb_median_filter_stream;

  localparam int NI = 3;

  logic clk = 1'b0;
  logic rst_n;
  logic flush;
  logic in_valid;
  logic [7:0] in_data;
  logic out_ready;
  logic [NI-1:0] ir;
  logic [NI-1:0] ov;
  logic [NI-1:0][7:0] od;

  int total = 0;
  int bad = 0;

  int  m_win [NI] = '{3, 3, 5};
  bit  m_sgn [NI] = '{1'b1, 1'b0, 1'b0};
  logic [7:0] hist [NI][$];
  bit  mv [NI];
  logic [7:0] md [NI];

  always #5 clk = ~clk;

  median_filter_stream #(.DATA_W(8), .WIN(3), .SIGNED(1)) u_a (
    .clk(clk), .rst_n(rst_n), .flush(flush), .in_valid(in_valid), .in_data(in_data),
    .in_ready(ir[0]), .out_valid(ov[0]), .out_data(od[0]), .out_ready(out_ready));
  median_filter_stream #(.DATA_W(8), .WIN(3), .SIGNED(0)) u_b (
    .clk(clk), .rst_n(rst_n), .flush(flush), .in_valid(in_valid), .in_data(in_data),
    .in_ready(ir[1]), .out_valid(ov[1]), .out_data(od[1]), .out_ready(out_ready));
  median_filter_stream #(.DATA_W(8), .WIN(5), .SIGNED(0)) u_c (
    .clk(clk), .rst_n(rst_n), .flush(flush), .in_valid(in_valid), .in_data(in_data),
    .in_ready(ir[2]), .out_valid(ov[2]), .out_data(od[2]), .out_ready(out_ready));

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Sort (ordering key, window index) pairs and return the middle one's sample.
  function automatic logic [7:0] ref_median(input logic [7:0] q[$], input bit sgn);
    int keys[$];
    int tmp;
    int n;
    n = q.size();
    for (int i = 0; i < n; i++) begin
      tmp = sgn ? int'(q[i] ^ 8'h80) : int'(q[i]);
      keys.push_back(tmp * 16 + i);
    end
    for (int a = 0; a < n; a++) begin
      for (int b = 0; b < n - 1 - a; b++) begin
        if (keys[b] > keys[b+1]) begin
          tmp = keys[b]; keys[b] = keys[b+1]; keys[b+1] = tmp;
        end
      end
    end
    return q[keys[(n-1)/2] % 16];
  endfunction

  task automatic model_reset();
    for (int k = 0; k < NI; k++) begin
      hist[k].delete();
      mv[k] = 1'b0;
      md[k] = 8'h00;
    end
  endtask

  task automatic step(input bit v, input logic [7:0] d, input bit f, input bit r);
    bit rdy [NI];
    in_valid = v; in_data = d; flush = f; out_ready = r;
    @(negedge clk);
    for (int k = 0; k < NI; k++) begin
      rdy[k] = !mv[k] || r;
      chk($sformatf("in_ready[%0d]", k), 32'(ir[k]), 32'(rdy[k]));
    end
    @(posedge clk);
    for (int k = 0; k < NI; k++) begin
      if (f) begin
        hist[k].delete();
        mv[k] = 1'b0;
      end else begin
        if (r) mv[k] = 1'b0;
        if (v && rdy[k]) begin
          hist[k].push_front(d);
          if (hist[k].size() > m_win[k]) void'(hist[k].pop_back());
          if (hist[k].size() == m_win[k]) begin
            mv[k] = 1'b1;
            md[k] = ref_median(hist[k], m_sgn[k]);
          end
        end
      end
    end
    #1;
    for (int k = 0; k < NI; k++) begin
      chk($sformatf("out_valid[%0d]", k), 32'(ov[k]), 32'(mv[k]));
      if (mv[k]) chk($sformatf("out_data[%0d]", k), 32'(od[k]), 32'(md[k]));
    end
  endtask

  initial begin
    rst_n = 1'b0; flush = 1'b0; in_valid = 1'b0; in_data = 8'h00; out_ready = 1'b1;
    model_reset();
    #12;
    chk("reset_out_valid", 32'(ov), 32'(3'b000));
    chk("reset_out_data_a", 32'(od[0]), 32'h0);
    chk("reset_in_ready", 32'(ir), 32'(3'b111));
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk); #1;

    // Signed window 10,-5,3: nothing until the third sample.
    step(1'b1, 8'h0A, 1'b0, 1'b1);
    step(1'b1, 8'hFB, 1'b0, 1'b1);
    chk("fill_no_out", 32'(ov[0]), 32'h0);
    step(1'b1, 8'h03, 1'b0, 1'b1);
    chk("first_valid", 32'(ov[0]), 32'h1);
    chk("first_med_s", 32'(od[0]), 32'h03);
    chk("first_med_u", 32'(od[1]), 32'h0A);

    // Signed vs unsigned ordering, then ties.
    step(1'b1, 8'h55, 1'b1, 1'b1);
    step(1'b1, 8'hF0, 1'b0, 1'b1);
    step(1'b1, 8'h10, 1'b0, 1'b1);
    step(1'b1, 8'h80, 1'b0, 1'b1);
    chk("sign_med_s", 32'(od[0]), 32'hF0);
    chk("sign_med_u", 32'(od[1]), 32'h80);
    step(1'b1, 8'h07, 1'b0, 1'b1);
    chk("mix_med_s", 32'(od[0]), 32'h07);
    chk("mix_med_u", 32'(od[1]), 32'h10);
    step(1'b1, 8'h07, 1'b0, 1'b1);
    chk("dup_med_u", 32'(od[1]), 32'h07);
    step(1'b1, 8'h02, 1'b0, 1'b1);
    chk("tie_med_s", 32'(od[0]), 32'h07);
    chk("tie_med_u", 32'(od[1]), 32'h07);

    // Five-wide window.
    step(1'b0, 8'h00, 1'b1, 1'b1);
    step(1'b1, 8'd1, 1'b0, 1'b1);
    step(1'b1, 8'd9, 1'b0, 1'b1);
    step(1'b1, 8'd4, 1'b0, 1'b1);
    step(1'b1, 8'd9, 1'b0, 1'b1);
    chk("w5_fill", 32'(ov[2]), 32'h0);
    step(1'b1, 8'd0, 1'b0, 1'b1);
    chk("w5_med0", 32'(od[2]), 32'd4);
    step(1'b1, 8'd2, 1'b0, 1'b1);
    chk("w5_med1", 32'(od[2]), 32'd4);

    // Backpressure: held output, stalled input, then in-order resume.
    for (int c = 0; c < 5; c++) begin
      step(1'b1, 8'h20, 1'b0, 1'b0);
      chk("bp_hold", 32'(od[0]), 32'h02);
      chk("bp_stall", 32'(ir), 32'(3'b000));
    end
    step(1'b1, 8'h20, 1'b0, 1'b1);
    chk("bp_resume0", 32'(od[0]), 32'h02);
    step(1'b1, 8'h30, 1'b0, 1'b1);
    chk("bp_resume1", 32'(od[0]), 32'h20);

    // Flush with a concurrent sample offered.
    step(1'b0, 8'h00, 1'b1, 1'b1);
    step(1'b1, 8'h11, 1'b0, 1'b1);
    step(1'b1, 8'h12, 1'b0, 1'b1);
    step(1'b1, 8'h77, 1'b1, 1'b1);
    step(1'b1, 8'h01, 1'b0, 1'b1);
    step(1'b1, 8'h02, 1'b0, 1'b1);
    chk("flush_no_out", 32'(ov[0]), 32'h0);
    step(1'b1, 8'h03, 1'b0, 1'b1);
    chk("flush_med", 32'(od[0]), 32'h02);

    // Asynchronous reset between clock edges.
    in_valid = 1'b0; out_ready = 1'b0;
    #2;
    rst_n = 1'b0;
    #1;
    chk("arst_valid", 32'(ov), 32'(3'b000));
    chk("arst_data", 32'(od[0]), 32'h0);
    chk("arst_ready", 32'(ir), 32'(3'b111));
    model_reset();
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk); #1;
    step(1'b1, 8'h05, 1'b0, 1'b1);
    step(1'b1, 8'h06, 1'b0, 1'b1);
    chk("arst_refill", 32'(ov[0]), 32'h0);
    step(1'b1, 8'h04, 1'b0, 1'b1);
    chk("arst_med", 32'(od[0]), 32'h05);

    // Random traffic.
    for (int c = 0; c < 400; c++) begin
      step(($urandom % 4) != 0, 8'($urandom), ($urandom % 32) == 0, ($urandom % 4) != 0);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
